pipe_skid_reg: RTL and testbench

PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

---
 rtl/pipe_skid_reg_if.sv | 23 ++
 rtl/pipe_skid_reg.sv | 109 ++++++++++
 tb/tb_pipe_skid_reg.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_skid_reg_if.sv
// Handshake bundle for pipe_skid_reg: upstream valid/ready/data, downstream valid/ready/data
// and the occupancy count. The slave modport is the stage itself.
interface pipe_skid_reg_if #(
    parameter int WIDTH = 96
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [1:0]       occupancy;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, occupancy
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, occupancy
    );
endinterface

// File: rtl/pipe_skid_reg.sv
// Pipeline stage register with an optional skid entry so that in_ready can come from a flop
// (SKID=1), or a plain single-entry stage whose in_ready follows out_ready (SKID=0).
module pipe_skid_reg #(
    parameter int               WIDTH  = 96,
    parameter logic [WIDTH-1:0] BUBBLE = {WIDTH{1'b0}},
    parameter int               SKID   = 1
) (
    input logic            clk,
    input logic            rst,
    input logic            flush,
    pipe_skid_reg_if.slave bus
);
    // Encoding equals the number of held entries, so occupancy is the state itself.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] main_q, main_d;
    logic [WIDTH-1:0] skid_q, skid_d;
    logic             in_ready;
    logic             out_valid;
    logic             accept;
    logic             consume;

    assign out_valid = (state_q != EMPTY);
    assign accept    = bus.in_valid && in_ready;
    assign consume   = out_valid && bus.out_ready;

    generate
        if (SKID != 0) begin : g_skid
            logic in_ready_q, in_ready_d;

            assign in_ready_d = (state_d != FULL);

            always_ff @(posedge clk) begin
                if (rst) begin
                    in_ready_q <= 1'b1;
                end else begin
                    in_ready_q <= in_ready_d;
                end
            end

            assign in_ready = in_ready_q;
        end else begin : g_single
            assign in_ready = !out_valid || bus.out_ready;
        end
    endgenerate

    always_comb begin
        // NOTE: every signal gets a default first so no path through the case leaves it unassigned (no latch).
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;

        case (state_q)
            EMPTY: begin
                if (accept) begin
                    state_d = ONE;
                    main_d  = bus.in_data;
                end
            end
            ONE: begin
                if (accept && consume) begin
                    main_d = bus.in_data;
                end else if (accept && (SKID != 0)) begin
                    state_d = FULL;
                    skid_d  = bus.in_data;
                end else if (consume) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (consume) begin
                    state_d = ONE;
                    main_d  = skid_q;
                end
            end
            default: state_d = EMPTY;
        endcase

        // Flush overrides any same-cycle accept or consume.
        if (flush) begin
            state_d = EMPTY;
        end
    end

    // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: payload registers carry no reset; validity lives in state_q and out_data is masked to BUBBLE.
    always_ff @(posedge clk) begin
        main_q <= main_d;
        skid_q <= skid_d;
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.out_data  = out_valid ? main_q : BUBBLE;
    assign bus.occupancy = state_q;
endmodule

// File: tb/tb_pipe_skid_reg.sv
// Bench for pipe_skid_reg: both SKID modes run side by side on shared stimulus, checked
// every cycle against queue-based models, plus directed literal expectations.
module tb_pipe_skid_reg;
    localparam int W = 96;
    localparam logic [W-1:0] BUB = 96'hB0BB_1E00_0000_0000_DEAD_BEEF;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         flush = 1'b0;
    logic         in_valid = 1'b0;
    logic [W-1:0] in_data = '0;
    logic         out_ready = 1'b0;
    logic         cmp_en = 1'b0;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pipe_skid_reg_if #(.WIDTH(W)) if1 ();
    pipe_skid_reg_if #(.WIDTH(W)) if0 ();

    assign if1.in_valid  = in_valid;
    assign if1.in_data   = in_data;
    assign if1.out_ready = out_ready;
    assign if0.in_valid  = in_valid;
    assign if0.in_data   = in_data;
    assign if0.out_ready = out_ready;

    pipe_skid_reg #(.WIDTH(W), .BUBBLE(BUB), .SKID(1)) dut1 (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (if1.slave)
    );

    pipe_skid_reg #(.WIDTH(W), .BUBBLE(BUB), .SKID(0)) dut0 (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (if0.slave)
    );

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference models: each stage is a FIFO of payloads with capacity 2 (SKID=1) or 1 (SKID=0).
    logic [W-1:0] q1[$];
    logic [W-1:0] q0[$];

    function automatic logic exp_ready1();
        return q1.size() < 2;
    endfunction

    function automatic logic exp_ready0();
        return (q0.size() == 0) || out_ready;
    endfunction

    always @(posedge clk) begin : model
        logic r1, r0;
        r1 = exp_ready1();
        r0 = exp_ready0();
        if (rst || flush) begin
            q1.delete();
            q0.delete();
        end else begin
            if (q1.size() > 0 && out_ready) void'(q1.pop_front());
            if (in_valid && r1) q1.push_back(in_data);
            if (q0.size() > 0 && out_ready) void'(q0.pop_front());
            if (in_valid && r0) q0.push_back(in_data);
        end
    end

    always @(negedge clk) begin : compare
        if (cmp_en) begin
            check("s1_in_ready", W'(if1.in_ready), W'(exp_ready1()));
            check("s1_out_valid", W'(if1.out_valid), W'(q1.size() > 0));
            check("s1_out_data", if1.out_data, (q1.size() > 0) ? q1[0] : BUB);
            check("s1_occupancy", W'(if1.occupancy), W'(q1.size()));
            check("s0_in_ready", W'(if0.in_ready), W'(exp_ready0()));
            check("s0_out_valid", W'(if0.out_valid), W'(q0.size() > 0));
            check("s0_out_data", if0.out_data, (q0.size() > 0) ? q0[0] : BUB);
            check("s0_occupancy", W'(if0.occupancy), W'(q0.size()));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        // Reset and idle state
        cyc();
        cyc();
        rst = 1'b0;
        cmp_en = 1'b1;
        settle();
        check("rst_in_ready1", W'(if1.in_ready), W'(1));
        check("rst_in_ready0", W'(if0.in_ready), W'(1));
        check("rst_out_valid1", W'(if1.out_valid), W'(0));
        check("rst_out_data1", if1.out_data, BUB);
        check("rst_occ1", W'(if1.occupancy), W'(0));

        // Streaming 1,2,3 with out_ready held high
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            in_data = W'(i);
            cyc();
            settle();
            check("stream_data1", if1.out_data, W'(i));
            check("stream_occ1", W'(if1.occupancy), W'(1));
            check("stream_data0", if0.out_data, W'(i));
        end
        in_valid = 1'b0;
        cyc();
        settle();
        check("stream_drain_valid1", W'(if1.out_valid), W'(0));
        check("stream_drain_data1", if1.out_data, BUB);

        // Skid fill with stalled output, then drain in order
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = W'('hA);
        cyc();
        in_data = W'('hB);
        cyc();
        in_valid = 1'b0;
        settle();
        check("full_occ1", W'(if1.occupancy), W'(2));
        check("full_in_ready1", W'(if1.in_ready), W'(0));
        check("full_data1", if1.out_data, W'('hA));
        check("single_occ0", W'(if0.occupancy), W'(1));
        out_ready = 1'b1;
        settle();
        check("drain_first1", if1.out_data, W'('hA));
        cyc();
        settle();
        check("drain_second1", if1.out_data, W'('hB));
        cyc();
        settle();
        check("drain_done_valid1", W'(if1.out_valid), W'(0));
        check("drain_done_data1", if1.out_data, BUB);

        // Flush while full, with same-cycle accept and consume offered
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = W'('hA);
        cyc();
        in_data = W'('hB);
        cyc();
        flush     = 1'b1;
        out_ready = 1'b1;
        in_data   = W'('hC);
        cyc();
        flush    = 1'b0;
        in_valid = 1'b0;
        settle();
        check("flush_occ1", W'(if1.occupancy), W'(0));
        check("flush_valid1", W'(if1.out_valid), W'(0));
        check("flush_in_ready1", W'(if1.in_ready), W'(1));
        check("flush_occ0", W'(if0.occupancy), W'(0));
        for (int i = 0; i < 3; i++) begin
            cyc();
            settle();
            check("flush_stays_empty1", if1.out_data, BUB);
        end

        // Single-entry mode: in_ready follows out_ready while holding
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = W'('h4);
        cyc();
        settle();
        check("s0_stall_in_ready", W'(if0.in_ready), W'(0));
        check("s0_stall_data", if0.out_data, W'('h4));
        out_ready = 1'b1;
        in_data   = W'('h5);
        settle();
        check("s0_pass_in_ready", W'(if0.in_ready), W'(1));
        cyc();
        settle();
        check("s0_pass_data", if0.out_data, W'('h5));
        in_valid = 1'b0;
        cyc();
        cyc();
        settle();
        check("s0_pass_drained", W'(if0.out_valid), W'(0));

        // Reset mid-transfer from FULL
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = W'('hA);
        cyc();
        in_data = W'('hB);
        cyc();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        rst       = 1'b1;
        cyc();
        rst = 1'b0;
        settle();
        check("midrst_valid1", W'(if1.out_valid), W'(0));
        check("midrst_occ1", W'(if1.occupancy), W'(0));
        check("midrst_data1", if1.out_data, BUB);
        check("midrst_in_ready1", W'(if1.in_ready), W'(1));
        in_valid = 1'b1;
        in_data  = W'('h7);
        cyc();
        in_valid = 1'b0;
        settle();
        check("postrst_data1", if1.out_data, W'('h7));
        check("postrst_occ1", W'(if1.occupancy), W'(1));
        cyc();
        settle();
        check("postrst_alone1", W'(if1.out_valid), W'(0));

        // Randomized traffic with occasional flush and reset
        for (int n = 0; n < 10000; n++) begin
            int bias;
            bias      = (n / 1000) % 3;
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = {$urandom, $urandom, $urandom};
            out_ready = (bias == 0) ? ($urandom_range(0, 3) == 0)
                      : (bias == 1) ? ($urandom_range(0, 1) == 1)
                      : ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 40) == 0);
            rst       = ($urandom_range(0, 600) == 0);
            cyc();
        end
        rst   = 1'b0;
        flush = 1'b0;
        cyc();
        cyc();

        cmp_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
